// File: rtl/arb_rr_4.sv
// Four-way round-robin arbiter with a bounded hold time per grant.
// A registered 2-bit owner index is decoded to a one-hot grant vector.
// Every grant ends with a one-cycle bubble, which gives the resource a clean handover point.

// 2-to-4 one-hot decoder.
module decoder_2to4 (
   input  logic [1:0] in,
   output logic [3:0] out
);

   // Drive the single bit selected by the input index.
   always_comb begin
      out     = '0;
      out[in] = 1'b1;
   end

endmodule

module arb_rr_4 #(
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] req,
   output logic [3:0] gnt,
   output logic [1:0] gnt_idx,
   output logic       gnt_valid,
   output logic       preempt
);

   localparam int unsigned N_REQ = 4;
   localparam int unsigned IDX_W = 2;
   localparam int unsigned CNT_W = 8;
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t           state;
   state_t           state_next;
   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] ptr_next;
   logic [IDX_W-1:0] idx_next;
   logic [IDX_W-1:0] winner;
   logic [CNT_W-1:0] hold_cnt;
   logic [CNT_W-1:0] hold_next;
   logic             valid_next;
   logic             preempt_next;
   logic             any_req;
   logic             owner_req;
   logic             hold_done;
   logic             release_now;
   logic [N_REQ-1:0] dec_out;

   assign any_req     = |req;
   assign owner_req   = req[gnt_idx];
   assign hold_done   = (hold_cnt == HOLD_LAST);
   assign release_now = !owner_req || hold_done;

   // Rotating priority search: the lowest offset from ptr with a request wins.
   always_comb begin
      winner = ptr;
      for (int k = N_REQ - 1; k >= 0; k--) begin
         if (req[ptr + IDX_W'(k)]) begin
            winner = ptr + IDX_W'(k);
         end
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= '0;
         hold_cnt  <= '0;
         gnt_idx   <= '0;
         gnt_valid <= 1'b0;
         preempt   <= 1'b0;
      end else begin
         state     <= state_next;
         ptr       <= ptr_next;
         hold_cnt  <= hold_next;
         gnt_idx   <= idx_next;
         gnt_valid <= valid_next;
         preempt   <= preempt_next;
      end
   end

   // Next-state: enter GRANT on any request, leave on release or hold limit.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (any_req) state_next = GRANT;
         GRANT:   if (release_now) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Next values of pointer, hold counter and registered outputs.
   always_comb begin
      ptr_next     = ptr;
      hold_next    = hold_cnt;
      idx_next     = gnt_idx;
      valid_next   = gnt_valid;
      preempt_next = 1'b0;
      case (state)
         IDLE: begin
            if (any_req) begin
               idx_next   = winner;
               valid_next = 1'b1;
               hold_next  = '0;
            end
         end
         GRANT: begin
            if (release_now) begin
               valid_next   = 1'b0;
               ptr_next     = gnt_idx + IDX_W'(1);
               // Owner still requesting at release means the hold limit revoked it.
               preempt_next = owner_req;
            end else begin
               hold_next = hold_cnt + CNT_W'(1);
            end
         end
         default: begin
            valid_next = 1'b0;
         end
      endcase
   end

   decoder_2to4 u_dec (
      .in  (gnt_idx),
      .out (dec_out)
   );

   // One-hot grant, forced to zero when no grant is active.
   assign gnt = dec_out & {N_REQ{gnt_valid}};

endmodule
